// File: rtl/ctrl_pipe_cond.sv
// Back-end control pipeline with ARM condition gating in Execute.
// Holds the NZCV flags and squashes side-effect bits of failed instructions.
module ctrl_pipe_cond #(
  parameter int                CTRL_W     = 12,
  parameter int                NUM_STAGES = 3,
  parameter logic [CTRL_W-1:0] GATE_MASK  = 'h0FF,
  parameter int                BRANCH_BIT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CTRL_W-1:0]            ctrl_d,
  input  logic                         valid_d,
  input  logic [3:0]                   cond_d,
  input  logic                         flag_write_d,
  input  logic [3:0]                   alu_flags,
  input  logic [NUM_STAGES-1:0]        stall,
  input  logic [NUM_STAGES-1:0]        flush,
  output logic [NUM_STAGES*CTRL_W-1:0] ctrl_q,
  output logic [NUM_STAGES-1:0]        valid_q,
  output logic                         cond_ex,
  output logic                         branch_taken_e,
  output logic [3:0]                   flags_q
);

  logic [CTRL_W-1:0]     st_ctrl_q [NUM_STAGES];
  logic [CTRL_W-1:0]     st_ctrl_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] st_vld_q;
  logic [NUM_STAGES-1:0] st_vld_d;
  logic [3:0]            e0_cond_q;
  logic [3:0]            e0_cond_d;
  logic                  e0_fw_q;
  logic                  e0_fw_d;
  logic [3:0]            flg_d;
  logic                  flg_n;
  logic                  flg_z;
  logic                  flg_c;
  logic                  flg_v;
  logic                  pass;
  logic [CTRL_W-1:0]     gated;

  assign {flg_n, flg_z, flg_c, flg_v} = flags_q;

  always_comb begin
    pass = 1'b1;
    case (e0_cond_q)
      4'd0:    pass = flg_z;
      4'd1:    pass = ~flg_z;
      4'd2:    pass = flg_c;
      4'd3:    pass = ~flg_c;
      4'd4:    pass = flg_n;
      4'd5:    pass = ~flg_n;
      4'd6:    pass = flg_v;
      4'd7:    pass = ~flg_v;
      4'd8:    pass = flg_c & ~flg_z;
      4'd9:    pass = ~flg_c | flg_z;
      4'd10:   pass = (flg_n == flg_v);
      4'd11:   pass = (flg_n != flg_v);
      4'd12:   pass = ~flg_z & (flg_n == flg_v);
      4'd13:   pass = flg_z | (flg_n != flg_v);
      default: pass = 1'b1;
    endcase
  end

  assign cond_ex        = pass & st_vld_q[0];
  assign branch_taken_e = st_ctrl_q[0][BRANCH_BIT] & cond_ex;
  assign gated          = st_ctrl_q[0] & ~(GATE_MASK & {CTRL_W{~cond_ex}});

  always_comb begin
    st_ctrl_d = st_ctrl_q;
    st_vld_d  = st_vld_q;
    e0_cond_d = e0_cond_q;
    e0_fw_d   = e0_fw_q;
    flg_d     = flags_q;
    if (flush[0]) begin
      st_ctrl_d[0] = '0;
      st_vld_d[0]  = 1'b0;
      e0_cond_d    = '0;
      e0_fw_d      = 1'b0;
    end else if (!stall[0]) begin
      st_ctrl_d[0] = ctrl_d;
      st_vld_d[0]  = valid_d;
      e0_cond_d    = cond_d;
      e0_fw_d      = flag_write_d;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (flush[i] || (!stall[i] && stall[i-1])) begin
        st_ctrl_d[i] = '0;
        st_vld_d[i]  = 1'b0;
      end else if (!stall[i]) begin
        st_ctrl_d[i] = (i == 1) ? gated : st_ctrl_q[i-1];
        st_vld_d[i]  = st_vld_q[i-1];
      end
    end
    // Only a retiring-from-E, condition-passing S instruction writes NZCV
    if (st_vld_q[0] && e0_fw_q && cond_ex && !stall[0] && !flush[0])
      flg_d = alu_flags;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGES; i++)
        st_ctrl_q[i] <= '0;
      st_vld_q  <= '0;
      e0_cond_q <= '0;
      e0_fw_q   <= 1'b0;
      flags_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++)
        st_ctrl_q[i] <= st_ctrl_d[i];
      st_vld_q  <= st_vld_d;
      e0_cond_q <= e0_cond_d;
      e0_fw_q   <= e0_fw_d;
      flags_q   <= flg_d;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
    assign ctrl_q[g*CTRL_W +: CTRL_W] = st_ctrl_q[g];
  end

  assign valid_q = st_vld_q;

endmodule

// File: tb/tb_ctrl_pipe_cond.sv
// Self-checking bench for ctrl_pipe_cond.
// Directed scenarios plus a queued scoreboard for random traffic.
module tb_ctrl_pipe_cond;

  localparam int          W  = 12;
  localparam int          NS = 3;
  localparam logic [11:0] GM = 12'h0FF;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ctrl_d;
  logic          valid_d;
  logic [3:0]    cond_d;
  logic          flag_write_d;
  logic [3:0]    alu_flags;
  logic [NS-1:0] stall;
  logic [NS-1:0] flush;
  logic [NS*W-1:0] ctrl_q;
  logic [NS-1:0] valid_q;
  logic          cond_ex;
  logic          branch_taken_e;
  logic [3:0]    flags_q;

  int errors = 0;
  int checks = 0;

  ctrl_pipe_cond #(
    .CTRL_W(W), .NUM_STAGES(NS), .GATE_MASK(GM), .BRANCH_BIT(0)
  ) dut (
    .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d),
    .cond_d(cond_d), .flag_write_d(flag_write_d),
    .alu_flags(alu_flags), .stall(stall), .flush(flush),
    .ctrl_q(ctrl_q), .valid_q(valid_q), .cond_ex(cond_ex),
    .branch_taken_e(branch_taken_e), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] st(input int i);
    return ctrl_q[i*W +: W];
  endfunction

  function automatic logic cond_ok(input logic [3:0] f,
                                   input logic [3:0] c);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[3:1] != 3'd7) r = r ^ c[0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_d = '0; valid_d = 0; cond_d = 4'd14;
    flag_write_d = 0; alu_flags = '0; stall = '0; flush = '0;
  endtask

  task automatic drive(input logic [W-1:0] c, input logic [3:0] cc,
                       input logic fw);
    ctrl_d = c; valid_d = 1; cond_d = cc; flag_write_d = fw;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    ctrl_d = 12'hFFF; valid_d = 1;
    tick();
    tick();
    checks++;
    if (ctrl_q !== '0 || valid_q !== '0 || flags_q !== '0) begin
      errors++;
      $display("FAIL reset_state: ctrl=%h valid=%b flags=%b, want 0",
               ctrl_q, valid_q, flags_q);
    end
    checks++;
    if (cond_ex !== 0 || branch_taken_e !== 0) begin
      errors++;
      $display("FAIL reset_cond: cond_ex=%b br=%b, want 0 0",
               cond_ex, branch_taken_e);
    end
    reset = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_flow();
    do_reset();
    drive(12'hABC, 4'd14, 0);
    tick();
    idle_inputs();
    checks++;
    if (st(0) !== 12'hABC || valid_q !== 3'b001) begin
      errors++;
      $display("FAIL flow_s0: ctrl=%h valid=%b, want abc 001",
               st(0), valid_q);
    end
    tick();
    checks++;
    if (st(1) !== 12'hABC || valid_q !== 3'b010 || st(0) !== 0) begin
      errors++;
      $display("FAIL flow_s1: s1=%h s0=%h valid=%b, want abc 000 010",
               st(1), st(0), valid_q);
    end
    tick();
    checks++;
    if (st(2) !== 12'hABC || valid_q !== 3'b100) begin
      errors++;
      $display("FAIL flow_s2: s2=%h valid=%b, want abc 100",
               st(2), valid_q);
    end
    tick();
    checks++;
    if (ctrl_q !== '0 || valid_q !== '0) begin
      errors++;
      $display("FAIL flow_drain: ctrl=%h valid=%b, want 0 0",
               ctrl_q, valid_q);
    end
  endtask

  task automatic test_cond_gate();
    do_reset();
    drive(12'hFFF, 4'd0, 0);
    tick();
    idle_inputs();
    checks++;
    if (cond_ex !== 0) begin
      errors++;
      $display("FAIL gate_cond_ex: got %b want 0", cond_ex);
    end
    tick();
    checks++;
    if (st(1) !== 12'hF00 || valid_q[1] !== 1) begin
      errors++;
      $display("FAIL gate_s1: ctrl=%h valid=%b, want f00 1",
               st(1), valid_q[1]);
    end
  endtask

  task automatic test_flags();
    do_reset();
    drive(12'h010, 4'd14, 1);
    tick();
    alu_flags = 4'b0100;
    drive(12'h020, 4'd0, 0);
    tick();
    checks++;
    if (flags_q !== 4'b0100) begin
      errors++;
      $display("FAIL flags_write: got %b want 0100", flags_q);
    end
    checks++;
    if (cond_ex !== 1) begin
      errors++;
      $display("FAIL flags_eq_after: cond_ex=%b want 1", cond_ex);
    end
    drive(12'h030, 4'd1, 1);
    tick();
    alu_flags = 4'b0011;
    idle_inputs();
    alu_flags = 4'b0011;
    checks++;
    if (cond_ex !== 0) begin
      errors++;
      $display("FAIL flags_ne_cond: cond_ex=%b want 0", cond_ex);
    end
    tick();
    checks++;
    if (flags_q !== 4'b0100) begin
      errors++;
      $display("FAIL flags_ne_hold: got %b want 0100", flags_q);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(12'h123, 4'd14, 1);
    tick();
    alu_flags = 4'b1000;
    stall = 3'b001;
    drive(12'h456, 4'd14, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (st(0) !== 12'h123 || valid_q[0] !== 1 || valid_q[1] !== 0) begin
        errors++;
        $display("FAIL stall_hold%0d: s0=%h v=%b, want 123 v0=1 v1=0",
                 k, st(0), valid_q);
      end
      checks++;
      if (flags_q !== 4'b0000) begin
        errors++;
        $display("FAIL stall_flags%0d: got %b want 0000", k, flags_q);
      end
    end
    idle_inputs();
    alu_flags = 4'b1000;
    tick();
    checks++;
    if (st(1) !== 12'h123 || valid_q[1] !== 1 || flags_q !== 4'b1000) begin
      errors++;
      $display("FAIL stall_release: s1=%h v1=%b flags=%b, want 123 1 1000",
               st(1), valid_q[1], flags_q);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(12'h001, 4'd14, 0);
    tick();
    idle_inputs();
    checks++;
    if (branch_taken_e !== 1) begin
      errors++;
      $display("FAIL flush_pre_br: got %b want 1", branch_taken_e);
    end
    stall = 3'b001;
    flush = 3'b001;
    tick();
    idle_inputs();
    checks++;
    if (valid_q !== 3'b000 || st(0) !== 0 || branch_taken_e !== 0) begin
      errors++;
      $display("FAIL flush_prio: v=%b s0=%h br=%b, want 000 000 0",
               valid_q, st(0), branch_taken_e);
    end
  endtask

  task automatic test_branch_reset();
    do_reset();
    drive(12'h801, 4'd12, 0);
    tick();
    drive(12'h040, 4'd14, 1);
    checks++;
    if (branch_taken_e !== 1 || cond_ex !== 1) begin
      errors++;
      $display("FAIL branch_gt: br=%b cond=%b, want 1 1",
               branch_taken_e, cond_ex);
    end
    tick();
    alu_flags = 4'b1010;
    valid_d = 0;
    tick();
    checks++;
    if (flags_q !== 4'b1010 || valid_q !== 3'b110) begin
      errors++;
      $display("FAIL branch_pre_rst: flags=%b v=%b, want 1010 110",
               flags_q, valid_q);
    end
    drive(12'h801, 4'd14, 0);
    tick();
    #3;
    reset = 0;
    #1;
    checks++;
    if (ctrl_q !== '0 || valid_q !== '0 || flags_q !== '0 ||
        cond_ex !== 0 || branch_taken_e !== 0) begin
      errors++;
      $display("FAIL async_reset: ctrl=%h v=%b f=%b c=%b br=%b, want 0",
               ctrl_q, valid_q, flags_q, cond_ex, branch_taken_e);
    end
    reset = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sb[$];
    logic [3:0]   mflags;
    logic [3:0]   cur_af;
    logic [3:0]   nxt_af;
    logic [W-1:0] c;
    logic [3:0]   cc;
    logic         fw;
    logic [W-1:0] exp_c;
    do_reset();
    mflags = '0;
    cur_af = '0;
    for (int k = 0; k < 64; k++) begin
      alu_flags = cur_af;
      nxt_af = '0;
      if (k < 60 && $urandom_range(3) != 0) begin
        c = W'($urandom);
        cc = 4'($urandom);
        fw = 1'($urandom);
        nxt_af = 4'($urandom);
        drive(c, cc, fw);
        if (cond_ok(mflags, cc)) begin
          exp_c = c;
          if (fw) mflags = nxt_af;
        end else begin
          exp_c = c & ~GM;
        end
        sb.push_back(exp_c);
      end else begin
        valid_d = 0;
        ctrl_d = W'($urandom);
      end
      tick();
      cur_af = nxt_af;
      if (valid_q[2]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got %h with empty queue", st(2));
        end else begin
          exp_c = sb.pop_front();
          if (st(2) !== exp_c) begin
            errors++;
            $display("FAIL b2b_data: got %h want %h", st(2), exp_c);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_lost: %0d entries never emerged", sb.size());
    end
    checks++;
    if (flags_q !== mflags) begin
      errors++;
      $display("FAIL b2b_flags: got %b want %b", flags_q, mflags);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_flow();
    test_cond_gate();
    test_flags();
    test_stall();
    test_flush();
    test_branch_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_cond.md
Name: ctrl_pipe_cond

Overview:
- Parametrised control-signal pipeline for the pipelined core, sitting after decode.
- Carries a CTRL_W-bit decoded control bundle from decode through NUM_STAGES back-end stages, with per-stage stall and flush.
- Evaluates the ARM condition field in stage 0 (Execute) against an internal NZCV flags register and squashes side-effect bits of failed instructions before they leave Execute.
- Improves on the fixed three-stage controller: arbitrary bundle width and depth, stall (hold) support, and flags written only by condition-passing instructions.

Parameters:
- CTRL_W, 12, width of the control bundle per stage.
- NUM_STAGES, 3, number of back-end stages (0=E, 1=M, 2=W, ...); legal range 2..8.
- GATE_MASK, 12'h0FF, bundle bits cleared when the condition fails (RegWrite, MemWrite, PCSrc, ...); width CTRL_W.
- BRANCH_BIT, 0, index of the Branch bit inside the bundle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- ctrl_d  in  CTRL_W  decoded control bundle from decode.
- valid_d  in  1  decode holds a real instruction.
- cond_d  in  4  condition field of the decode instruction.
- flag_write_d  in  1  decode instruction sets flags (S bit).
- alu_flags  in  4  NZCV from the Execute ALU, same cycle.
- stall  in  NUM_STAGES  per-stage hold.
- flush  in  NUM_STAGES  per-stage bubble insert.
- ctrl_q  out  NUM_STAGES*CTRL_W  stage i bundle at bits [i*CTRL_W +: CTRL_W].
- valid_q  out  NUM_STAGES  stage valid bits.
- cond_ex  out  1  stage-0 condition passes and stage 0 is valid.
- branch_taken_e  out  1  stage-0 bundle[BRANCH_BIT] & cond_ex.
- flags_q  out  4  architectural NZCV (N=bit3, Z=2, C=1, V=0).

Behaviour:
- Reset (reset=0, asynchronous): all ctrl_q, valid_q, stage-0 cond and flag_write registers, and flags_q go to 0. cond_ex=0 and branch_taken_e=0 while reset is asserted.
- Per stage i, at each clock edge, the first matching rule applies:
  - flush[i]=1: valid=0 and ctrl=0 (bubble). Flush overrides stall.
  - stall[i]=1: stage holds its contents.
  - stall[i-1]=1 with stall[i]=0 (i>0): stage i receives a bubble.
  - otherwise: stage i loads from its source. Stage 0 loads ctrl_d, valid_d, cond_d, flag_write_d. Stage 1 loads ctrl_q[0] with GATE_MASK bits ANDed with cond_ex. Stage i>1 loads stage i-1 unchanged.
- For i>0, a bubble entering stage i has valid=0 and ctrl=0.
- Stage 0 bubbles come from flush[0] only.
- Condition decode (combinational, on the stage-0 cond field and flags_q):
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V.
  - 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V; 12 GT ~Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL and 15 both evaluate 1.
  - cond_ex = decode result & valid_q[0].
- Flags update: flags_q <= alu_flags at an edge only when valid_q[0], the stage-0 flag_write bit, and cond_ex are all 1, and stall[0]=0 and flush[0]=0.
  - An instruction entering E on the following cycle therefore sees the new flags with one cycle of latency; no bypass is needed.
- Latency: ctrl_d appears in stage 0 one cycle after capture, in stage i after i+1 cycles when there are no stalls.
- A failed condition in stage 0 still advances with valid=1; only GATE_MASK bits are zeroed in stage 1.
- A stage stalled for many cycles keeps cond_ex stable, because flags cannot change while stage 0 is held.
- Reset mid-stream: all in-flight instructions are discarded, and the pipeline restarts empty with flags=0.

Test Plan:
- Flow: valid_d=1 with ctrl_d=12'hABC for one cycle, cond AL, no stall/flush -> ctrl_q stage0=ABC at cycle 1, stage1=ABC at cycle 2, stage2=ABC at cycle 3; then 0 with valid 0.
- Condition gate: flags_q=4'b0000, stage-0 ctrl=12'hFFF with cond EQ -> cond_ex=0, and stage 1 receives 12'hF00 with valid=1.
- Flags update rule:
  - Stage 0 has S=1, cond AL, alu_flags=4'b0100 -> flags_q=4'b0100 next cycle, so a following EQ instruction gets cond_ex=1.
  - Same case with cond NE when Z=1 -> flags_q unchanged.
- Stall/bubble: stall=3'b001 for 2 cycles with stage0=12'h123 -> stage 0 holds 123 and stage 1 receives 2 bubbles (valid 0); flags_q is not written during the stall even with S=1.
- Flush priority: stall[0]=1 and flush[0]=1 in the same cycle -> stage 0 becomes a bubble and branch_taken_e=0 next cycle.
- Branch and reset: ctrl bit0=1 with cond GT, flags N=0 Z=0 V=0 -> branch_taken_e=1; then reset low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
